// File: rtl/johnson_pkg.sv
// Shared constants for the parametrised Johnson/ring counter.
// Mode and direction encodings used by the counter and its phase decoder.
package johnson_pkg;

  localparam logic MODE_JOHNSON = 1'b0;
  localparam logic MODE_RING    = 1'b1;

  localparam logic DIR_UP       = 1'b0;
  localparam logic DIR_DOWN     = 1'b1;

  typedef enum logic [1:0] {
    ACT_MODE = 2'd0,
    ACT_LOAD = 2'd1,
    ACT_FIX  = 2'd2,
    ACT_STEP = 2'd3
  } act_e;

endpackage

// File: rtl/johnson_phase_decode.sv
// Combinational legality check and phase index for a Johnson or ring code.
// An illegal code decodes to phase 0.
module johnson_phase_decode
  import johnson_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int PW    = $clog2(2*WIDTH)
) (
  input  logic [WIDTH-1:0] i_q,
  input  logic             i_mode,
  output logic             o_legal,
  output logic [PW-1:0]    o_phase
);

  int w_pop;
  int w_trans;
  int w_idx;

  logic          w_legal_j;
  logic          w_legal_r;
  logic [PW-1:0] w_phase_j;
  logic [PW-1:0] w_phase_r;

  always_comb begin
    w_pop   = 0;
    w_trans = 0;
    w_idx   = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i_q[i]) begin
        w_pop = w_pop + 1;
        w_idx = i;
      end
    end
    for (int i = 0; i < WIDTH-1; i++) begin
      if (i_q[i] != i_q[i+1]) begin
        w_trans = w_trans + 1;
      end
    end
  end

  // Johnson: the fill length counts up in the first half, down in the second.
  always_comb begin
    w_legal_j = (w_trans <= 1);
    w_legal_r = (w_pop == 1);
    if (i_q[WIDTH-1]) begin
      w_phase_j = PW'(2*WIDTH - w_pop);
    end else begin
      w_phase_j = PW'(w_pop);
    end
    w_phase_r = PW'(w_idx);
  end

  always_comb begin
    o_legal = 1'b0;
    o_phase = '0;
    if (i_mode == MODE_RING) begin
      o_legal = w_legal_r;
      o_phase = w_legal_r ? w_phase_r : '0;
    end else begin
      o_legal = w_legal_j;
      o_phase = w_legal_j ? w_phase_j : '0;
    end
  end

endmodule

// File: rtl/johnson_counter_gen.sv
// Parametrised twisted-ring / ring counter with prescaler, load,
// illegal-code self-correction, wrap and error pulses.
module johnson_counter_gen
  import johnson_pkg::*;
#(
  parameter  int WIDTH = 4,
  parameter  int DIV_W = 8,
  localparam int PW    = $clog2(2*WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             dir_i,
  input  logic             mode_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] q_o,
  output logic [PW-1:0]    phase_o,
  output logic             wrap_o,
  output logic             err_o
);

  logic [WIDTH-1:0] r_q;
  logic             r_mode;
  logic [DIV_W-1:0] r_div_cnt;
  logic             r_wrap;
  logic             r_err;

  logic             w_legal;
  logic [PW-1:0]    w_phase;
  logic             w_tick;
  logic [WIDTH-1:0] w_q_up;
  logic [WIDTH-1:0] w_q_dn;
  logic [WIDTH-1:0] w_q_step;
  logic [WIDTH-1:0] w_code0_new;
  logic [WIDTH-1:0] w_code0_cur;
  logic [PW-1:0]    w_last;
  logic             w_wrap_hit;
  act_e             w_act;

  johnson_phase_decode #(
    .WIDTH (WIDTH),
    .PW    (PW)
  ) u_dec (
    .i_q     (r_q),
    .i_mode  (r_mode),
    .o_legal (w_legal),
    .o_phase (w_phase)
  );

  always_comb begin
    w_tick = en_i && (r_div_cnt >= div_i);
    if (r_mode == MODE_RING) begin
      w_q_up = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
      w_q_dn = {r_q[0], r_q[WIDTH-1:1]};
      w_last = PW'(WIDTH - 1);
    end else begin
      w_q_up = {r_q[WIDTH-2:0], ~r_q[WIDTH-1]};
      w_q_dn = {~r_q[0], r_q[WIDTH-1:1]};
      w_last = PW'(2*WIDTH - 1);
    end
    w_q_step    = (dir_i == DIR_DOWN) ? w_q_dn : w_q_up;
    w_code0_new = (mode_i == MODE_RING) ? WIDTH'(1) : '0;
    w_code0_cur = (r_mode == MODE_RING) ? WIDTH'(1) : '0;
    w_wrap_hit  = (dir_i == DIR_DOWN) ? (w_phase == '0)
                                      : (w_phase == w_last);
  end

  // Highest-priority action for this edge; ACT_STEP also covers "no tick".
  always_comb begin
    if (mode_i != r_mode) begin
      w_act = ACT_MODE;
    end else if (load_i) begin
      w_act = ACT_LOAD;
    end else if (!w_legal) begin
      w_act = ACT_FIX;
    end else begin
      w_act = ACT_STEP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q       <= '0;
      r_mode    <= MODE_JOHNSON;
      r_div_cnt <= '0;
      r_wrap    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      r_err  <= 1'b0;
      if (w_tick) begin
        r_div_cnt <= '0;
      end else if (en_i) begin
        r_div_cnt <= r_div_cnt + DIV_W'(1);
      end
      unique case (w_act)
        ACT_MODE: begin
          r_mode    <= mode_i;
          r_q       <= w_code0_new;
          r_div_cnt <= '0;
        end
        ACT_LOAD: begin
          r_q       <= load_val_i;
          r_div_cnt <= '0;
        end
        ACT_FIX: begin
          r_q   <= w_code0_cur;
          r_err <= 1'b1;
        end
        ACT_STEP: begin
          if (w_tick) begin
            r_q    <= w_q_step;
            r_wrap <= w_wrap_hit;
          end
        end
        default: ;
      endcase
    end
  end

  assign q_o     = r_q;
  assign phase_o = w_phase;
  assign wrap_o  = r_wrap;
  assign err_o   = r_err;

endmodule

// File: tb/tb_johnson_counter_gen.sv
// Scoreboard bench for johnson_counter_gen at WIDTH=4, DIV_W=8.
// Expected q/phase/wrap/err are queued per edge and checked after it.
module tb_johnson_counter_gen;

  localparam int W  = 4;
  localparam int DW = 8;
  localparam int PW = 3;

  logic          clk;
  logic          rst;
  logic          en_i;
  logic          dir_i;
  logic          mode_i;
  logic [DW-1:0] div_i;
  logic          load_i;
  logic [W-1:0]  load_val_i;
  logic [W-1:0]  q_o;
  logic [PW-1:0] phase_o;
  logic          wrap_o;
  logic          err_o;

  typedef struct {
    logic [W-1:0]  q;
    logic [PW-1:0] ph;
    logic          wr;
    logic          er;
  } exp_t;

  exp_t sb[$];
  int n_cmp;
  int n_bad;

  johnson_counter_gen #(
    .WIDTH (W),
    .DIV_W (DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en_i       (en_i),
    .dir_i      (dir_i),
    .mode_i     (mode_i),
    .div_i      (div_i),
    .load_i     (load_i),
    .load_val_i (load_val_i),
    .q_o        (q_o),
    .phase_o    (phase_o),
    .wrap_o     (wrap_o),
    .err_o      (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
               $time);
    end
  endtask

  // Queue the expectation, take one edge, then pop and compare.
  task automatic cyc(input string tag, input logic [W-1:0] q,
                     input logic [PW-1:0] ph, input logic wr,
                     input logic er);
    exp_t e;
    e.q  = q;
    e.ph = ph;
    e.wr = wr;
    e.er = er;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_q"},    32'(q_o),     32'(e.q));
      chk({tag, "_ph"},   32'(phase_o), 32'(e.ph));
      chk({tag, "_wrap"}, 32'(wrap_o),  32'(e.wr));
      chk({tag, "_err"},  32'(err_o),   32'(e.er));
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp,
             n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    rst        = 1'b1;
    en_i       = 1'b0;
    dir_i      = 1'b0;
    mode_i     = 1'b0;
    div_i      = '0;
    load_i     = 1'b0;
    load_val_i = '0;
    #23;
    chk("rst_q",    32'(q_o),     32'd0);
    chk("rst_ph",   32'(phase_o), 32'd0);
    chk("rst_wrap", 32'(wrap_o),  32'd0);
    chk("rst_err",  32'(err_o),   32'd0);
    rst  = 1'b0;
    @(posedge clk);
    #1;
    en_i = 1'b1;

    cyc("up1", 4'b0001, 3'd1, 1'b0, 1'b0);
    cyc("up2", 4'b0011, 3'd2, 1'b0, 1'b0);
    cyc("up3", 4'b0111, 3'd3, 1'b0, 1'b0);
    cyc("up4", 4'b1111, 3'd4, 1'b0, 1'b0);
    cyc("up5", 4'b1110, 3'd5, 1'b0, 1'b0);
    cyc("up6", 4'b1100, 3'd6, 1'b0, 1'b0);
    cyc("up7", 4'b1000, 3'd7, 1'b0, 1'b0);
    cyc("upw", 4'b0000, 3'd0, 1'b1, 1'b0);

    dir_i = 1'b1;
    cyc("dnw", 4'b1000, 3'd7, 1'b1, 1'b0);
    cyc("dn6", 4'b1100, 3'd6, 1'b0, 1'b0);

    dir_i = 1'b0;
    div_i = 8'd2;
    cyc("pre_h1", 4'b1100, 3'd6, 1'b0, 1'b0);
    cyc("pre_h2", 4'b1100, 3'd6, 1'b0, 1'b0);
    cyc("pre_t",  4'b1000, 3'd7, 1'b0, 1'b0);
    cyc("pre_h3", 4'b1000, 3'd7, 1'b0, 1'b0);
    en_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc("en_off", 4'b1000, 3'd7, 1'b0, 1'b0);
    end
    en_i = 1'b1;
    cyc("resid_h", 4'b1000, 3'd7, 1'b0, 1'b0);
    cyc("resid_t", 4'b0000, 3'd0, 1'b1, 1'b0);

    div_i = '0;
    cyc("j1", 4'b0001, 3'd1, 1'b0, 1'b0);
    cyc("j2", 4'b0011, 3'd2, 1'b0, 1'b0);
    cyc("j3", 4'b0111, 3'd3, 1'b0, 1'b0);

    mode_i = 1'b1;
    cyc("to_ring", 4'b0001, 3'd0, 1'b0, 1'b0);
    cyc("r1", 4'b0010, 3'd1, 1'b0, 1'b0);
    cyc("r2", 4'b0100, 3'd2, 1'b0, 1'b0);
    cyc("r3", 4'b1000, 3'd3, 1'b0, 1'b0);
    cyc("rw", 4'b0001, 3'd0, 1'b1, 1'b0);
    dir_i = 1'b1;
    cyc("rdw", 4'b1000, 3'd3, 1'b1, 1'b0);
    dir_i = 1'b0;

    load_i     = 1'b1;
    load_val_i = 4'b0110;
    cyc("rld_bad", 4'b0110, 3'd0, 1'b0, 1'b0);
    load_i = 1'b0;
    cyc("rfix", 4'b0001, 3'd0, 1'b0, 1'b1);

    mode_i = 1'b0;
    cyc("to_john", 4'b0000, 3'd0, 1'b0, 1'b0);
    load_i     = 1'b1;
    load_val_i = 4'b0101;
    cyc("jld_bad", 4'b0101, 3'd0, 1'b0, 1'b0);
    load_i = 1'b0;
    cyc("jfix", 4'b0000, 3'd0, 1'b0, 1'b1);
    cyc("jafter", 4'b0001, 3'd1, 1'b0, 1'b0);
    load_i     = 1'b1;
    load_val_i = 4'b0011;
    cyc("jld_ok", 4'b0011, 3'd2, 1'b0, 1'b0);
    load_i = 1'b0;
    cyc("jld_nx", 4'b0111, 3'd3, 1'b0, 1'b0);

    div_i = 8'd5;
    cyc("dl_h1", 4'b0111, 3'd3, 1'b0, 1'b0);
    cyc("dl_h2", 4'b0111, 3'd3, 1'b0, 1'b0);
    cyc("dl_h3", 4'b0111, 3'd3, 1'b0, 1'b0);
    div_i = 8'd1;
    cyc("dl_t",  4'b1111, 3'd4, 1'b0, 1'b0);
    cyc("dl_h4", 4'b1111, 3'd4, 1'b0, 1'b0);
    cyc("dl_t2", 4'b1110, 3'd5, 1'b0, 1'b0);

    div_i  = '0;
    mode_i = 1'b1;
    #3;
    rst = 1'b1;
    #1;
    chk("arst_q",    32'(q_o),     32'd0);
    chk("arst_ph",   32'(phase_o), 32'd0);
    chk("arst_wrap", 32'(wrap_o),  32'd0);
    chk("arst_err",  32'(err_o),   32'd0);
    #2;
    rst = 1'b0;
    cyc("post_rst", 4'b0001, 3'd0, 1'b0, 1'b0);
    cyc("post_r1",  4'b0010, 3'd1, 1'b0, 1'b0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp,
             n_bad);
    $finish;
  end

endmodule
